// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the default halt opcode and the I-type opcode constants used by this ISA.
package fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

  // Width of an instruction word and of the opcode field in instr[31:26].
  localparam int unsigned InstrWidth  = 32;
  localparam int unsigned OpcodeWidth = 6;
  localparam int unsigned OpcodeLsb   = 26;

  // Opcode that stops fetch when it would be issued.
  localparam logic [OpcodeWidth-1:0] HaltOpcodeDefault = 6'b111111;

  // I-type opcodes (register/immediate forms handled by the downstream ALU).
  localparam logic [OpcodeWidth-1:0] OpAddi = 6'h14;
  localparam logic [OpcodeWidth-1:0] OpAndi = 6'h15;
  localparam logic [OpcodeWidth-1:0] OpOri  = 6'h16;
  localparam logic [OpcodeWidth-1:0] OpXori = 6'h17;
  localparam logic [OpcodeWidth-1:0] OpLw   = 6'h20;
  localparam logic [OpcodeWidth-1:0] OpSw   = 6'h28;
  localparam logic [OpcodeWidth-1:0] OpBeq  = 6'h04;
  localparam logic [OpcodeWidth-1:0] OpBne  = 6'h05;

  // Extract the opcode field of an instruction word.
  function automatic logic [OpcodeWidth-1:0] opcode_of(input logic [InstrWidth-1:0] w);
    return w[InstrWidth-1:OpcodeLsb];
  endfunction

  // Increment a 16-bit counter, sticking at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/instr_memory.sv
// Instruction memory: synchronous write port for programming, asynchronous
// read port for same-cycle fetch. No reset, so contents survive rst.
module instr_memory #(
  parameter int unsigned WORDS = 64,
  localparam int unsigned AW   = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];

  // Program port: write one word per enabled cycle.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Fetch port: combinational read.
  always_comb begin
    o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: IDLE (programming) -> RUN (fetch with ready/valid
// backpressure and redirect) -> HALT (sticky until rst). Outputs are registered.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned      IMEM_WORDS  = 64,
  parameter logic [31:0]      RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]       HALT_OPCODE = HaltOpcodeDefault,
  localparam int unsigned     AW          = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic          ready,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   instr,
  output logic [31:0]   pc_out,
  output logic [31:0]   pc_plus4,
  output logic          instr_valid,
  output logic          halted,
  output logic [15:0]   fetch_count
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc_out;
  logic [31:0]  r_pc_plus4;
  logic         r_instr_valid;
  logic         r_halted;
  logic [15:0]  r_fetch_count;

  logic          w_imem_we;
  logic [AW-1:0] w_rd_addr;
  logic [31:0]   w_rd_data;
  logic [31:0]   w_pc_next;
  logic          w_fetch_slot;
  logic          w_is_halt;

  // Programming is only allowed while idle, and a reset cycle never writes.
  assign w_imem_we    = (r_state == StIdle) && prog_we && !rst;
  // Word index ignores the byte offset and any bits above the memory size.
  assign w_rd_addr    = r_pc[AW+1:2];
  assign w_pc_next    = r_pc + 32'd4;
  assign w_fetch_slot = (r_state == StRun) && (!r_instr_valid || ready);
  assign w_is_halt    = (opcode_of(w_rd_data) == HALT_OPCODE);

  instr_memory #(
    .WORDS (IMEM_WORDS)
  ) u_imem (
    .clk     (clk),
    .i_we    (w_imem_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Fetch sequencer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_pc_out      <= 32'd0;
      r_pc_plus4    <= 32'd0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= 16'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StRun;
          end
        end
        StRun: begin
          if (redirect) begin
            // Flush wins over both backpressure and a pending halt word.
            r_pc          <= redirect_pc;
            r_instr_valid <= 1'b0;
          end else if (w_fetch_slot) begin
            if (w_is_halt) begin
              // Halt word is consumed silently; pc stays pointing at it.
              r_state       <= StHalt;
              r_halted      <= 1'b1;
              r_instr_valid <= 1'b0;
            end else begin
              r_instr       <= w_rd_data;
              r_pc_out      <= r_pc;
              r_pc_plus4    <= w_pc_next;
              r_instr_valid <= 1'b1;
              r_pc          <= w_pc_next;
              r_fetch_count <= sat_inc16(r_fetch_count);
            end
          end
        end
        StHalt: begin
          r_instr_valid <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign instr       = r_instr;
  assign pc_out      = r_pc_out;
  assign pc_plus4    = r_pc_plus4;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: programming, basic fetch to halt, stall,
// redirect under stall and over a halt word, reset restart, address wrap.
module tb_instr_fetch;

  localparam int unsigned AW = 6;

  logic          clk;
  logic          rst;
  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          ready;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   instr;
  logic [31:0]   pc_out;
  logic [31:0]   pc_plus4;
  logic          instr_valid;
  logic          halted;
  logic [15:0]   fetch_count;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [31:0] W0  = 32'h5401_0005;
  localparam logic [31:0] W1  = 32'h5009_0002;
  localparam logic [31:0] W2  = 32'hFC00_0000;
  localparam logic [31:0] W4  = 32'h1234_5678;
  localparam logic [31:0] W63 = 32'h0BAD_F00D;

  instr_fetch #(
    .IMEM_WORDS  (64),
    .RESET_PC    (32'h0000_0000),
    .HALT_OPCODE (6'b111111)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .ready       (ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [AW-1:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (instr !== 32'd0) begin
      n_fail++; $display("FAIL reset_instr: got %h want %h", instr, 32'd0);
    end
    n_cmp++;
    if (pc_out !== 32'd0 || pc_plus4 !== 32'd0) begin
      n_fail++; $display("FAIL reset_pc: got %h/%h want 0/0", pc_out, pc_plus4);
    end
    n_cmp++;
    if (instr_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got v=%b h=%b want 0/0", instr_valid, halted);
    end
    n_cmp++;
    if (fetch_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", fetch_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_program();
    prog(6'd0, W0);
    prog(6'd1, W1);
    prog(6'd2, W2);
    prog(6'd4, W4);
    prog(6'd63, W63);
    n_cmp++;
    if (instr_valid !== 1'b0 || fetch_count !== 16'd0) begin
      n_fail++; $display("FAIL idle_quiet: got v=%b cnt=%0d want 0/0", instr_valid, fetch_count);
    end
  endtask

  task automatic test_basic_to_halt();
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if (instr !== W0 || pc_out !== 32'h0 || pc_plus4 !== 32'h4 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_first: got %h@%h +4=%h v=%b want %h@0 +4=4 v=1",
                         instr, pc_out, pc_plus4, instr_valid, W0);
    end
    tick();
    n_cmp++;
    if (instr !== W1 || pc_out !== 32'h4 || pc_plus4 !== 32'h8 || fetch_count !== 16'd2) begin
      n_fail++; $display("FAIL basic_second: got %h@%h +4=%h cnt=%0d want %h@4 +4=8 cnt=2",
                         instr, pc_out, pc_plus4, fetch_count, W1);
    end
    tick();
    n_cmp++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || fetch_count !== 16'd2) begin
      n_fail++; $display("FAIL basic_halt: got h=%b v=%b cnt=%0d want 1/0/2",
                         halted, instr_valid, fetch_count);
    end
    // HALT ignores redirect and start
    redirect    = 1'b1;
    redirect_pc = 32'h10;
    start       = 1'b1;
    tick();
    tick();
    redirect = 1'b0;
    start    = 1'b0;
    n_cmp++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || fetch_count !== 16'd2 || pc_out !== 32'h4) begin
      n_fail++; $display("FAIL halt_sticky: got h=%b v=%b cnt=%0d pc=%h want 1/0/2/4",
                         halted, instr_valid, fetch_count, pc_out);
    end
  endtask

  task automatic test_stall();
    do_reset();
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (instr !== W0 || pc_out !== 32'h0 || fetch_count !== 16'd1 || instr_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h@%h cnt=%0d v=%b want %h@0 cnt=1 v=1",
                           i, instr, pc_out, fetch_count, instr_valid, W0);
      end
    end
  endtask

  task automatic test_redirect_stall();
    redirect    = 1'b1;
    redirect_pc = 32'h10;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_flush: got v=%b want 0", instr_valid);
    end
    tick();
    n_cmp++;
    if (pc_out !== 32'h10 || instr !== W4 || instr_valid !== 1'b1 || fetch_count !== 16'd2) begin
      n_fail++; $display("FAIL redir_target: got %h@%h v=%b cnt=%0d want %h@10 v=1 cnt=2",
                         instr, pc_out, instr_valid, fetch_count, W4);
    end
    // Programming attempt in RUN must be dropped.
    prog(6'd0, 32'hDEAD_BEEF);
  endtask

  task automatic test_rst_restart();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b0 || fetch_count !== 16'd0 || pc_out !== 32'd0 || instr !== 32'd0) begin
      n_fail++; $display("FAIL midrun_rst: got v=%b cnt=%0d pc=%h i=%h want 0/0/0/0",
                         instr_valid, fetch_count, pc_out, instr);
    end
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if (pc_out !== 32'h0 || instr !== W0 || fetch_count !== 16'd1) begin
      n_fail++; $display("FAIL restart: got %h@%h cnt=%0d want %h@0 cnt=1",
                         instr, pc_out, fetch_count, W0);
    end
  endtask

  task automatic test_wrap();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    tick();
    n_cmp++;
    if (instr !== W0 || pc_out !== 32'h100 || pc_plus4 !== 32'h104) begin
      n_fail++; $display("FAIL wrap_index: got %h@%h +4=%h want %h@100 +4=104",
                         instr, pc_out, pc_plus4, W0);
    end
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    n_cmp++;
    if (instr !== W63 || pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL wrap_top: got %h@%h +4=%h want %h@fffffffc +4=0",
                         instr, pc_out, pc_plus4, W63);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_cmp++;
    if (instr !== W0 || pc_out !== 32'h0 || fetch_count !== 16'd4) begin
      n_fail++; $display("FAIL wrap_32: got %h@%h cnt=%0d want %h@0 cnt=4",
                         instr, pc_out, fetch_count, W0);
    end
  endtask

  task automatic test_redirect_over_halt();
    do_reset();
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    // pc now points at the halt word
    redirect    = 1'b1;
    redirect_pc = 32'h10;
    tick();
    redirect = 1'b0;
    ready    = 1'b0;
    n_cmp++;
    if (halted !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_halt_flush: got h=%b v=%b want 0/0", halted, instr_valid);
    end
    tick();
    n_cmp++;
    if (halted !== 1'b0 || pc_out !== 32'h10 || instr !== W4 || fetch_count !== 16'd3) begin
      n_fail++; $display("FAIL redir_halt_resume: got h=%b %h@%h cnt=%0d want 0 %h@10 cnt=3",
                         halted, instr, pc_out, fetch_count, W4);
    end
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_data   = 32'd0;
    ready       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    test_reset();
    test_program();
    test_basic_to_halt();
    test_stall();
    test_redirect_stall();
    test_rst_restart();
    test_wrap();
    test_redirect_over_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
